// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between two requesters.
// Commands are latched on grant; a one-cycle RELEASE state keeps the controller enables low between accesses.
module sram_arb_port #(
    parameter int RDATA_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               done,
    input  logic               capture,
    input  logic [RDATA_W-1:0] mem_read_data,
    output logic               ready,
    output logic [RDATA_W-1:0] read_data
);
    logic               ready_q, ready_d;
    logic [RDATA_W-1:0] read_data_q, read_data_d;

    always_comb begin
        ready_d     = done;
        read_data_d = capture ? mem_read_data : read_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            read_data_q <= '0;
        end else begin
            ready_q     <= ready_d;
            read_data_q <= read_data_d;
        end
    end

    assign ready     = ready_q;
    assign read_data = read_data_q;
endmodule

module sram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               p0_rd_en,
    input  logic               p0_wr_en,
    input  logic [ADDR_W-1:0]  p0_address,
    input  logic [WDATA_W-1:0] p0_write_data,
    output logic               p0_ready,
    output logic [RDATA_W-1:0] p0_read_data,
    input  logic               p1_rd_en,
    input  logic               p1_wr_en,
    input  logic [ADDR_W-1:0]  p1_address,
    input  logic [WDATA_W-1:0] p1_write_data,
    output logic               p1_ready,
    output logic [RDATA_W-1:0] p1_read_data,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [WDATA_W-1:0] mem_write_data,
    input  logic               mem_ready,
    input  logic [RDATA_W-1:0] mem_read_data,
    output logic               busy
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    typedef struct packed {
        logic               wr;
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] wdata;
    } cmd_t;

    state_t                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic                    last_q, last_d;
    cmd_t                    cmd_q, cmd_d;
    logic                    mem_rd_en_q, mem_rd_en_d;
    logic                    mem_wr_en_q, mem_wr_en_d;
    logic                    win;

    logic [NUM_PORTS-1:0]              req;
    cmd_t [NUM_PORTS-1:0]              port_cmd;
    logic [NUM_PORTS-1:0]              port_done;
    logic [NUM_PORTS-1:0]              port_capture;
    logic [NUM_PORTS-1:0]              port_ready;
    logic [NUM_PORTS-1:0][RDATA_W-1:0] port_rdata;

    // A port asserting both enables is treated as a write.
    assign req[0]      = p0_rd_en | p0_wr_en;
    assign req[1]      = p1_rd_en | p1_wr_en;
    assign port_cmd[0] = '{wr: p0_wr_en, addr: p0_address, wdata: p0_write_data};
    assign port_cmd[1] = '{wr: p1_wr_en, addr: p1_address, wdata: p1_write_data};

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cmd_d       = cmd_q;
        mem_rd_en_d = mem_rd_en_q;
        mem_wr_en_d = mem_wr_en_q;
        win         = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win         = (req[0] && req[1]) ? ~last_q : req[1];
                    gnt_d       = win;
                    cmd_d       = port_cmd[win];
                    mem_wr_en_d = port_cmd[win].wr;
                    mem_rd_en_d = ~port_cmd[win].wr;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (mem_ready) begin
                    last_d      = gnt_q;
                    mem_rd_en_d = 1'b0;
                    mem_wr_en_d = 1'b0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            cmd_q       <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cmd_q       <= cmd_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
        end
    end

    // Completion is steered to the granted port; only reads update its data.
    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            assign port_done[i]    = (state_q == GRANT) && mem_ready && (gnt_q == 1'(i));
            assign port_capture[i] = port_done[i] && !cmd_q.wr;
            sram_arb_port #(.RDATA_W(RDATA_W)) u_port (
                .clk          (clk),
                .rst_n        (rst_n),
                .done         (port_done[i]),
                .capture      (port_capture[i]),
                .mem_read_data(mem_read_data),
                .ready        (port_ready[i]),
                .read_data    (port_rdata[i])
            );
        end
    endgenerate

    assign p0_ready       = port_ready[0];
    assign p1_ready       = port_ready[1];
    assign p0_read_data   = port_rdata[0];
    assign p1_read_data   = port_rdata[1];
    assign mem_rd_en      = mem_rd_en_q;
    assign mem_wr_en      = mem_wr_en_q;
    assign mem_address    = cmd_q.addr;
    assign mem_write_data = cmd_q.wdata;
    assign busy           = (state_q != IDLE);
endmodule
